// File: rtl/dual_port_mem_arb.sv
// True dual-port synchronous memory with post-reset clear sweep, registered
// read data with valid strobes, and deterministic same-address collision handling.
module dual_port_mem_arb #(
  parameter int unsigned    AW       = 3,
  parameter int unsigned    DW       = 4,
  parameter bit             PRIO_A   = 1'b1,
  parameter bit             RDW_MODE = 1'b0,
  parameter logic [DW-1:0]  INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          EnA,
  input  logic          rwA,
  input  logic [AW-1:0] AddrA,
  input  logic [DW-1:0] DataInA,
  output logic [DW-1:0] DataOutA,
  output logic          ValidA,
  input  logic          EnB,
  input  logic          rwB,
  input  logic [AW-1:0] AddrB,
  input  logic [DW-1:0] DataInB,
  output logic [DW-1:0] DataOutB,
  output logic          ValidB,
  output logic          Collision,
  output logic          Busy
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DW-1:0]   data_out_a_q, data_out_a_d;
  logic [DW-1:0]   data_out_b_q, data_out_b_d;
  logic            valid_a_q, valid_a_d;
  logic            valid_b_q, valid_b_d;
  logic            collision_q, collision_d;
  logic            busy_q, busy_d;

  logic [DW-1:0]   mem_q [DEPTH];

  logic            same_addr_c;
  logic            wr_a_c, wr_b_c, rd_a_c, rd_b_c;
  logic            we_a_c, we_b_c, we_clr_c;

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      data_out_a_q <= '0;
      data_out_b_q <= '0;
      valid_a_q    <= 1'b0;
      valid_b_q    <= 1'b0;
      collision_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      data_out_a_q <= data_out_a_d;
      data_out_b_q <= data_out_b_d;
      valid_a_q    <= valid_a_d;
      valid_b_q    <= valid_b_d;
      collision_q  <= collision_d;
      busy_q       <= busy_d;
    end
  end

  // Storage array has no reset; the clear sweep initialises it instead
  always_ff @(posedge clk) begin
    if (we_clr_c) begin
      mem_q[clr_cnt_q] <= INIT_VAL;
    end else begin
      if (we_a_c) mem_q[AddrA] <= DataInA;
      if (we_b_c) mem_q[AddrB] <= DataInB;
    end
  end

  // Next-state, arbitration and read-path logic
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    data_out_a_d = data_out_a_q;
    data_out_b_d = data_out_b_q;
    valid_a_d    = 1'b0;
    valid_b_d    = 1'b0;
    collision_d  = 1'b0;
    we_a_c       = 1'b0;
    we_b_c       = 1'b0;
    we_clr_c     = 1'b0;

    same_addr_c = EnA && EnB && (AddrA == AddrB);
    wr_a_c      = EnA && rwA;
    wr_b_c      = EnB && rwB;
    rd_a_c      = EnA && !rwA;
    rd_b_c      = EnB && !rwB;

    case (state_q)
      ST_CLEAR: begin
        we_clr_c  = 1'b1;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d   = ST_READY;
          clr_cnt_d = '0;
        end
      end
      ST_READY: begin
        // Losing port of a same-address double write is dropped
        we_a_c = wr_a_c && !(same_addr_c && wr_b_c && !PRIO_A);
        we_b_c = wr_b_c && !(same_addr_c && wr_a_c && PRIO_A);
        if (rd_a_c) begin
          valid_a_d    = 1'b1;
          data_out_a_d = (RDW_MODE && same_addr_c && wr_b_c) ? DataInB : mem_q[AddrA];
        end
        if (rd_b_c) begin
          valid_b_d    = 1'b1;
          data_out_b_d = (RDW_MODE && same_addr_c && wr_a_c) ? DataInA : mem_q[AddrB];
        end
        collision_d = same_addr_c && (wr_a_c || wr_b_c);
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    busy_d = (state_d == ST_CLEAR);
  end

  assign DataOutA  = data_out_a_q;
  assign DataOutB  = data_out_b_q;
  assign ValidA    = valid_a_q;
  assign ValidB    = valid_b_q;
  assign Collision = collision_q;
  assign Busy      = busy_q;

endmodule
